// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to single-cycle register-file strobe bridge.
// One transaction in flight; writes win over reads when both are presented.
module axil_reg_bridge #(
   parameter int AXI_AWIDTH = 12,
   parameter int AXI_DWIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [AXI_AWIDTH-1:0]   AWADDR,
   input  logic                    AWVALID,
   input  logic [2:0]              AWPROT,
   output logic                    AWREADY,
   input  logic [AXI_DWIDTH-1:0]   WDATA,
   input  logic [AXI_DWIDTH/8-1:0] WSTRB,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic                    BVALID,
   output logic [1:0]              BRESP,
   input  logic                    BREADY,
   input  logic [AXI_AWIDTH-1:0]   ARADDR,
   input  logic                    ARVALID,
   input  logic [2:0]              ARPROT,
   output logic                    ARREADY,
   output logic                    RVALID,
   output logic [AXI_DWIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   input  logic                    RREADY,
   output logic                    reg_wr_en,
   output logic                    reg_rd_en,
   output logic [AXI_AWIDTH-1:0]   reg_addr,
   output logic [AXI_DWIDTH-1:0]   reg_wdata,
   output logic [AXI_DWIDTH/8-1:0] reg_wstrb,
   input  logic                    reg_rd_data_valid,
   input  logic [AXI_DWIDTH-1:0]   reg_rd_data
);

   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR_ISSUE = 3'd1;
   localparam logic [2:0] WR_RESP  = 3'd2;
   localparam logic [2:0] RD_ISSUE = 3'd3;
   localparam logic [2:0] RD_WAIT  = 3'd4;
   localparam logic [2:0] RD_RESP  = 3'd5;

   logic [2:0]              state;
   logic                    aw_held, w_held;
   logic [AXI_AWIDTH-1:0]   aw_addr, rd_addr;
   logic [AXI_DWIDTH-1:0]   w_data, r_data;
   logic [AXI_DWIDTH/8-1:0] w_strb;
   logic [CW-1:0]           cnt;
   logic                    r_err;
   logic                    in_idle, aw_hs, w_hs, ar_hs, aw_got, w_got, wr_err;
   logic                    unused_prot;

   assign unused_prot = ^{AWPROT, ARPROT};

   assign in_idle = (state == IDLE) && !reset;
   assign AWREADY = in_idle && !aw_held;
   assign WREADY  = in_idle && !w_held;
   // A read is only taken when no write is pending or being offered.
   assign ARREADY = in_idle && !aw_held && !w_held && !AWVALID && !WVALID;

   assign aw_hs  = AWVALID && AWREADY;
   assign w_hs   = WVALID && WREADY;
   assign ar_hs  = ARVALID && ARREADY;
   assign aw_got = aw_held || aw_hs;
   assign w_got  = w_held || w_hs;
   assign wr_err = (aw_addr[1:0] != 2'b00);

   assign reg_wr_en = (state == WR_ISSUE) && !wr_err && (w_strb != '0);
   assign reg_rd_en = (state == RD_ISSUE);
   assign reg_addr  = reg_wr_en ? aw_addr : (reg_rd_en ? rd_addr : '0);
   assign reg_wdata = reg_wr_en ? w_data : '0;
   assign reg_wstrb = reg_wr_en ? w_strb : '0;

   assign BVALID = (state == WR_RESP);
   assign BRESP  = (BVALID && wr_err) ? 2'b10 : 2'b00;
   assign RVALID = (state == RD_RESP);
   assign RDATA  = RVALID ? r_data : '0;
   assign RRESP  = (RVALID && r_err) ? 2'b10 : 2'b00;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_addr <= '0;
         rd_addr <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
         cnt     <= '0;
      end else begin
         if (aw_hs) aw_addr <= AWADDR;
         if (w_hs) begin
            w_data <= WDATA;
            w_strb <= WSTRB;
         end
         case (state)
            IDLE: begin
               // Combine held and same-cycle handshakes so AW+W together issue next cycle.
               if (aw_got && w_got) begin
                  state   <= WR_ISSUE;
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
               end else begin
                  aw_held <= aw_got;
                  w_held  <= w_got;
                  if (ar_hs) begin
                     rd_addr <= ARADDR;
                     r_data  <= '0;
                     r_err   <= (ARADDR[1:0] != 2'b00);
                     state   <= (ARADDR[1:0] == 2'b00) ? RD_ISSUE : RD_RESP;
                  end
               end
            end
            WR_ISSUE: state <= WR_RESP;
            WR_RESP:  if (BREADY) state <= IDLE;
            RD_ISSUE: begin
               cnt   <= '0;
               state <= RD_WAIT;
            end
            RD_WAIT: begin
               // RD_WAIT lasts at most TIMEOUT cycles; a return on the last one still wins.
               if (reg_rd_data_valid) begin
                  r_data <= reg_rd_data;
                  r_err  <= 1'b0;
                  state  <= RD_RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  r_data <= '0;
                  r_err  <= 1'b1;
                  state  <= RD_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RD_RESP:  if (RREADY) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/axil_reg_bridge.md
AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- AXI_AWIDTH, 12, AXI-Lite address width.
- AXI_DWIDTH, 32, AXI-Lite data width; DWIDTH/8 strobe bits.
- TIMEOUT, 255, maximum RD_WAIT cycles before SLVERR.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high reset.
- AWADDR / AWVALID / AWPROT, in, AWIDTH/1/3, write address channel.
- AWREADY, out, 1, write address ready.
- WDATA / WSTRB / WVALID, in, DWIDTH/DWIDTH/8/1, write data channel.
- WREADY, out, 1, write data ready.
- BVALID / BRESP, out, 1/2, write response.
- BREADY, in, 1, write response accept.
- ARADDR / ARVALID / ARPROT, in, AWIDTH/1/3, read address channel.
- ARREADY, out, 1, read address ready.
- RVALID / RDATA / RRESP, out, 1/DWIDTH/2, read response.
- RREADY, in, 1, read response accept.
- reg_wr_en / reg_rd_en, out, 1/1, single-cycle register-file strobes.
- reg_addr / reg_wdata / reg_wstrb, out, AWIDTH/DWIDTH/DWIDTH/8, register request fields.
- reg_rd_data_valid / reg_rd_data, in, 1/DWIDTH, register read return.

REQ-003 One clock domain; reset SHALL be asynchronous, active-high.

Function
REQ-004 States SHALL be IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP; exactly one transaction outstanding.
REQ-005 In IDLE, AWREADY=!aw_held and WREADY=!w_held; AW and W SHALL be captured independently, in any order or in the same cycle.
REQ-006 When aw_held and w_held are both set, the FSM SHALL enter WR_ISSUE on the next edge; both flags clear on entry.
REQ-007 WR_ISSUE, one cycle: if AWADDR[1:0]==0 and WSTRB!=0, reg_wr_en=1 with reg_addr/reg_wdata/reg_wstrb from the captured values; otherwise no strobe.
REQ-008 WR_RESP: BVALID=1; BRESP=2'b10 (SLVERR) if unaligned, else 2'b00 (OKAY, including WSTRB==0); held stable until BREADY, then IDLE.
REQ-009 ARREADY=1 only in IDLE with aw_held=w_held=0 and AWVALID=WVALID=0; simultaneous AWVALID and ARVALID SHALL give the write priority.
REQ-010 After an AR handshake: if aligned, go to RD_ISSUE (reg_rd_en=1 for one cycle, reg_addr=ARADDR) then RD_WAIT; if unaligned, go directly to RD_RESP with RDATA=0, RRESP=SLVERR, and no reg_rd_en.
REQ-011 RD_WAIT: an 8+ bit counter SHALL clear on entry and increment each cycle; reg_rd_data_valid captures reg_rd_data with RRESP=OKAY and moves to RD_RESP.
REQ-012 If the counter reaches TIMEOUT without valid, go to RD_RESP with RDATA=0, RRESP=SLVERR; valid on the same cycle as the timeout SHALL win (OKAY).
REQ-013 RD_RESP: RVALID=1 with RDATA/RRESP held stable until RREADY, then IDLE.
REQ-014 reg_rd_data_valid outside RD_WAIT SHALL be ignored; AWPROT/ARPROT are ignored.
REQ-015 Latency: same-cycle AW+W handshake at cycle 0 gives reg_wr_en at cycle 1 and BVALID at cycle 2; AR at cycle 0 gives reg_rd_en at cycle 1; RVALID SHALL follow reg_rd_data_valid by one cycle.
REQ-016 All READY signals are 0 in every state other than IDLE.

Reset
REQ-017 During reset and after release, all outputs SHALL be 0 (READYs, VALIDs, RESPs, RDATA, reg_* strobes and fields), the FSM in IDLE, held flags and counter cleared.
REQ-018 Reset mid-transaction SHALL abandon it silently, with no B or R response after release.

Verification
REQ-019 AW 0x010 and W 0xA5A5A5A5/0xF in the same cycle -> reg_wr_en at cycle 1 with those values; BVALID, BRESP=00 at cycle 2; held through 3 cycles of BREADY=0.
REQ-020 W first, AW 0x020 three cycles later -> WREADY drops after W is captured; a single reg_wr_en; BRESP=00.
REQ-021 AR 0x004, reg_rd_data_valid with 0x12345678 four cycles after reg_rd_en -> RVALID next cycle, RDATA=0x12345678, RRESP=00.
REQ-022 AR 0x008 with no valid returned -> RVALID after TIMEOUT cycles, RDATA=0, RRESP=10; a valid on the exact timeout cycle gives OKAY.
REQ-023 AW 0x003 write and AR 0x001 read -> no reg strobes, BRESP=10, RRESP=10, RDATA=0.
REQ-024 AWVALID, WVALID and ARVALID in the same cycle -> write completes first, read accepted after the B handshake; reset asserted in RD_WAIT -> all outputs 0, no RVALID after release.
